note_seq_recorder: RTL and testbench
====================================

# note_seq_recorder

Multi-channel beat-quantised note recorder/player for the keyboard music game. It samples per-channel key codes once per beat into an on-chip slot memory during RECORD, and replays them beat by beat during PLAY, with optional looping. It sits between the key encoder and the frequency decoder / tone PWM. It is the parametrised successor of the single-voice record path: it adds channel count, depth and looping, and it auto-stops on full memory.

## Interface
Parameters:
- CHANNELS, 2, number of simultaneously recorded voices
- KEY_W, 6, key-code width per channel; code 0 = rest
- DEPTH, 512, slots (beats) of memory
- BEAT_DIV, 3125000, clock cycles per beat (16 Hz at 50 MHz); must be ≥ 4
- derived localparam ADDR_W = clog2(DEPTH)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rec_start  in  1  one-cycle pulse; begin recording
- play_start  in  1  one-cycle pulse; begin playback
- stop  in  1  one-cycle pulse; end record/play
- loop_en  in  1  level; wrap playback at end of recording
- live_keys  in  CHANNELS*KEY_W  current key code per channel; channel c occupies bits [c*KEY_W +: KEY_W]
- play_keys  out  CHANNELS*KEY_W  replayed key codes; 0 outside PLAY
- beat_num  out  ADDR_W  current slot
- rec_len  out  ADDR_W+1  number of valid recorded slots
- mode  out  2  0 IDLE, 1 RECORD, 2 PLAY
- done  out  1  one-cycle pulse when RECORD or PLAY ends by any cause except reset

## Operation
- Reset: mode=IDLE, play_keys=0, beat_num=0, rec_len=0, done=0. Memory contents are not cleared.
- Beat counter: runs 0..BEAT_DIV-1 in RECORD/PLAY; tick asserted when it equals BEAT_DIV-1. It is cleared on entry to either state and held at 0 in IDLE.
- IDLE: rec_start → RECORD with beat_num=0. play_start → PLAY with beat_num=0, only if rec_len≠0; otherwise ignored. Both pulses in the same cycle: rec_start wins. stop has no effect.
- rec_start/play_start are ignored outside IDLE.
- RECORD: on tick, write live_keys (sampled that cycle) to mem[beat_num], then beat_num++.
  - After the write to slot DEPTH-1: rec_len=DEPTH, go IDLE, done.
  - stop: rec_len=beat_num (slots already written), go IDLE, done. The partial beat is discarded.
  - stop coinciding with a tick: the write happens first, then stop.
- PLAY: play_keys = mem[beat_num] through a registered read.
  - On tick with beat_num=rec_len-1: if loop_en, beat_num=0; else go IDLE, play_keys=0, done.
  - Otherwise, on tick: beat_num++.
  - stop: go IDLE, play_keys=0, done. The next cycle beat_num=0.
- rec_len is changed only at the end of RECORD. A new RECORD overwrites from slot 0.

## Timing
- Pulse accepted at cycle 0; mode changes at cycle 1; counter=0 at cycle 1.
- First tick at cycle BEAT_DIV. Slot k is written at cycle BEAT_DIV*(k+1).
- PLAY read latency 2 cycles (address register → synchronous RAM → output register). play_keys shows mem[0] from cycle 2. After each tick, play_keys shows the new slot 2 cycles later. Slot k is therefore visible for BEAT_DIV cycles, offset by +2.
- End of PLAY: play_keys=0 and mode=IDLE in the cycle after the final tick or stop. done is high for exactly that one cycle.
- Asynchronous reset mid-operation: immediate IDLE, all outputs at reset values. Partial recording is lost (rec_len=0).

## Structure
- Shared package: mode encodings (MODE_IDLE/RECORD/PLAY) and the rest key code constant KEY_REST=0.
- Sub-module beat_ticker (parameter BEAT_DIV; ports clk, reset, clr, tick).
- Slot memory: inferred simple dual-port RAM, DEPTH × CHANNELS*KEY_W.
- FSM and address logic live in the top.

## Test plan
(CHANNELS=2, KEY_W=6, DEPTH=8, BEAT_DIV=4)
- Reset, then play_start → mode stays 0, play_keys=0, done never asserted.
- Record live_keys {ch1,ch0} = {0x00,0x05}, {0x02,0x11}, {0x3F,0x3F} on ticks at cycles 4, 8, 12; stop at cycle 14 → rec_len=3, done pulse at cycle 15, mode=0.
- Play with loop_en=0 → play_keys = 0x005, 0x091, 0xFFF at cycles 2, 6, 10; mode=0, play_keys=0, done at cycle 13.
- Record without stop → after the 8th tick: rec_len=8, mode=0, done; live_keys sampled later are never stored.
- Play with loop_en=1, rec_len=3 → beat_num sequence 0,1,2,0,1; stop mid-beat → next cycle play_keys=0, beat_num=0, done.
- Reset asserted mid-RECORD; rec_start and play_start together in IDLE → reset: all outputs at reset values, rec_len=0; simultaneous pulses: RECORD entered.

Source files
------------

// File: rtl/note_seq_recorder_pkg.sv
// Shared definitions for the beat-quantised note recorder: mode encodings and the rest key code.
`default_nettype none

package note_seq_recorder_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RECORD = 2'd1,
    MODE_PLAY   = 2'd2
  } mode_t;

  localparam int KEY_REST = 0;

endpackage

`default_nettype wire

// File: rtl/note_seq_recorder_ticker.sv
// beat_ticker: free-running beat counter that pulses tick on the last cycle of each beat.
`default_nettype none

module beat_ticker #(
  parameter int BEAT_DIV = 3125000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Gated by clr so a counter left mid-beat by a stop can never tick while idle.
  assign tick = (cnt == LAST) && !clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/note_seq_recorder.sv
// Multi-channel note recorder/player: samples key codes once per beat into slot memory and replays them.
`default_nettype none

module note_seq_recorder
  import note_seq_recorder_pkg::*;
#(
  parameter  int CHANNELS = 2,
  parameter  int KEY_W    = 6,
  parameter  int DEPTH    = 512,
  parameter  int BEAT_DIV = 3125000,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rec_start,
  input  logic                      play_start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [CHANNELS*KEY_W-1:0] live_keys,
  output logic [CHANNELS*KEY_W-1:0] play_keys,
  output logic [ADDR_W-1:0]         beat_num,
  output logic [ADDR_W:0]           rec_len,
  output logic [1:0]                mode,
  output logic                      done
);

  localparam int                DATA_W    = CHANNELS * KEY_W;
  localparam logic [DATA_W-1:0] REST_WORD = {CHANNELS{KEY_W'(KEY_REST)}};
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

  mode_t             state;
  logic              tick;
  logic              ticker_clr;
  logic [ADDR_W:0]   beat_next;
  logic              play_last;
  logic              play_end;
  logic [DATA_W-1:0] mem [DEPTH];

  assign mode       = state;
  assign ticker_clr = (state == MODE_IDLE);

  beat_ticker #(
    .BEAT_DIV (BEAT_DIV)
  ) u_ticker (
    .clk   (clk),
    .reset (reset),
    .clr   (ticker_clr),
    .tick  (tick)
  );

  // One bit wider than the address so it doubles as "slots written so far".
  assign beat_next = {1'b0, beat_num} + (ADDR_W + 1)'(1);
  assign play_last = (beat_next == rec_len);
  assign play_end  = stop || (tick && play_last && !loop_en);

  always_ff @(posedge clk) begin
    if (state == MODE_RECORD && tick) begin
      mem[beat_num] <= live_keys;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MODE_IDLE;
      beat_num  <= '0;
      rec_len   <= '0;
      play_keys <= REST_WORD;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      play_keys <= REST_WORD;
      case (state)
        MODE_IDLE: begin
          beat_num <= '0;
          if (rec_start) begin
            state <= MODE_RECORD;
          end else if (play_start && rec_len != '0) begin
            state <= MODE_PLAY;
          end
        end
        MODE_RECORD: begin
          if (tick && beat_num == LAST_SLOT) begin
            rec_len  <= FULL_LEN;
            state    <= MODE_IDLE;
            done     <= 1'b1;
            beat_num <= '0;
          end else if (stop) begin
            // A coinciding tick has already written its slot, so it counts.
            rec_len  <= tick ? beat_next : {1'b0, beat_num};
            state    <= MODE_IDLE;
            done     <= 1'b1;
            beat_num <= '0;
          end else if (tick) begin
            beat_num <= beat_next[ADDR_W-1:0];
          end
        end
        MODE_PLAY: begin
          if (play_end) begin
            state    <= MODE_IDLE;
            done     <= 1'b1;
            beat_num <= '0;
          end else begin
            play_keys <= mem[beat_num];
            if (tick) begin
              beat_num <= play_last ? '0 : beat_next[ADDR_W-1:0];
            end
          end
        end
        default: begin
          state <= MODE_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_seq_recorder.sv
// Randomized self-checking bench for note_seq_recorder against a beat-level arithmetic reference model.
`default_nettype none

module tb_note_seq_recorder;

  localparam int CH    = 2;
  localparam int KW    = 6;
  localparam int DEPTH = 8;
  localparam int BD    = 4;
  localparam int AW    = 3;
  localparam int DW    = CH * KW;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          rec_start  = 1'b0;
  logic          play_start = 1'b0;
  logic          stop       = 1'b0;
  logic          loop_en    = 1'b0;
  logic [DW-1:0] live_keys  = '0;
  logic [DW-1:0] play_keys;
  logic [AW-1:0] beat_num;
  logic [AW:0]   rec_len;
  logic [1:0]    mode;
  logic          done;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_mem [DEPTH];
  int            exp_len = 0;

  note_seq_recorder #(
    .CHANNELS (CH),
    .KEY_W    (KW),
    .DEPTH    (DEPTH),
    .BEAT_DIV (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .loop_en    (loop_en),
    .live_keys  (live_keys),
    .play_keys  (play_keys),
    .beat_num   (beat_num),
    .rec_len    (rec_len),
    .mode       (mode),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle t is the interval after the t-th edge following the start pulse.
  task automatic do_record(input int stop_at);
    int full_end;
    int e;
    int n_wr;
    full_end = BD * DEPTH;
    e        = (stop_at > 0 && stop_at < full_end) ? stop_at : full_end;
    n_wr     = (e / BD > DEPTH) ? DEPTH : e / BD;
    for (int t = 0; t <= e + 1; t++) begin
      if (t >= 1 && t <= e) begin
        check("rec_mode", 32'(mode), 32'd1);
        check("rec_done", 32'(done), 32'd0);
      end
      if (t == e + 1) begin
        check("rec_end_mode", 32'(mode), 32'd0);
        check("rec_end_done", 32'(done), 32'd1);
        check("rec_len", 32'(rec_len), 32'(n_wr));
      end
      live_keys = DW'($urandom);
      rec_start = (t == 0);
      stop      = (t == stop_at);
      if (t >= 1 && t <= e && t % BD == 0) exp_mem[t / BD - 1] = live_keys;
      next_cycle();
    end
    rec_start = 1'b0;
    stop      = 1'b0;
    check("rec_done_once", 32'(done), 32'd0);
    exp_len = n_wr;
  endtask

  task automatic do_play(input bit lp, input int stop_at);
    int fin;
    int e;
    loop_en = lp;
    if (exp_len == 0) begin
      play_start = 1'b1;
      next_cycle();
      play_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check("ign_mode", 32'(mode), 32'd0);
        check("ign_done", 32'(done), 32'd0);
        check("ign_keys", 32'(play_keys), 32'd0);
        next_cycle();
      end
      return;
    end
    fin = BD * exp_len;
    if (lp) e = stop_at;
    else    e = (stop_at > 0 && stop_at < fin) ? stop_at : fin;
    for (int t = 0; t <= e + 1; t++) begin
      if (t >= 1 && t <= e) begin
        check("play_mode", 32'(mode), 32'd2);
        check("play_done", 32'(done), 32'd0);
        check("play_beat", 32'(beat_num), 32'(((t - 1) / BD) % exp_len));
        if (t == 1) check("play_keys_first", 32'(play_keys), 32'd0);
        else        check("play_keys", 32'(play_keys), 32'(exp_mem[((t - 2) / BD) % exp_len]));
      end
      if (t == e + 1) begin
        check("play_end_mode", 32'(mode), 32'd0);
        check("play_end_done", 32'(done), 32'd1);
        check("play_end_keys", 32'(play_keys), 32'd0);
        check("play_end_beat", 32'(beat_num), 32'd0);
      end
      live_keys  = DW'($urandom);
      play_start = (t == 0);
      stop       = (t == stop_at);
      next_cycle();
    end
    play_start = 1'b0;
    stop       = 1'b0;
    check("play_done_once", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_keys", 32'(play_keys), 32'd0);
    check("rst_beat", 32'(beat_num), 32'd0);
    check("rst_len", 32'(rec_len), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    next_cycle();

    do_play(1'b0, 0);

    do_record(14);
    do_play(1'b0, 0);

    do_record(0);
    do_play(1'b0, 0);

    do_record(14);
    do_play(1'b1, 19);

    for (int it = 0; it < 8; it++) begin
      int s;
      int ps;
      bit lp;
      s  = int'($urandom_range(1, BD * DEPTH + 3));
      do_record(s);
      lp = 1'($urandom_range(0, 1));
      if (lp) ps = int'($urandom_range(1, 3 * BD * DEPTH));
      else    ps = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BD * DEPTH)) : 0;
      do_play(lp, ps);
    end

    // Make sure a nonzero length exists before the mid-record reset.
    do_record(9);
    rec_start = 1'b1;
    next_cycle();
    rec_start = 1'b0;
    repeat (6) begin
      live_keys = DW'($urandom);
      next_cycle();
    end
    #2 reset = 1'b0;
    #1;
    check("arst_mode", 32'(mode), 32'd0);
    check("arst_len", 32'(rec_len), 32'd0);
    check("arst_beat", 32'(beat_num), 32'd0);
    check("arst_keys", 32'(play_keys), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_len = 0;
    next_cycle();

    rec_start  = 1'b1;
    play_start = 1'b1;
    next_cycle();
    rec_start  = 1'b0;
    play_start = 1'b0;
    check("both_mode", 32'(mode), 32'd1);
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    check("both_stop_mode", 32'(mode), 32'd0);
    check("both_stop_done", 32'(done), 32'd1);
    check("both_stop_len", 32'(rec_len), 32'd0);
    next_cycle();
    do_play(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
